// File: rtl/sisc_pkg.sv
// Shared SISC constants: ALU op/funct codes, arbiter state encoding, stat bit layout.
// Pure definitions; no latency or backpressure of its own.
package sisc_pkg;

    localparam logic [1:0] ALU_OP_NOSTAT = 2'b10;
    localparam int         ALU_OP_IMM    = 0;

    localparam logic [3:0] FUNCT_ADD = 4'd1;
    localparam logic [3:0] FUNCT_SUB = 4'd2;

    localparam logic [1:0] ST_ARB  = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    localparam int STAT_C = 3;
    localparam int STAT_V = 2;
    localparam int STAT_N = 1;
    localparam int STAT_Z = 0;

    typedef struct packed {
        logic c;
        logic v;
        logic n;
        logic z;
    } stat_t;

    function automatic logic [1:0] own_state(input logic port);
        return port ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant with an ownership override; purely combinational.
// Latency 0; an owned arbiter only grants its owner, the other port simply waits.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       own_en,
    input  logic       own_port,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (own_en) begin
            grant[own_port] = valid[own_port];
        end else if (valid == 2'b11) begin
            // tie goes to the port that did not win last time
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares the SISC ALU between two requesters (round-robin, optional bounded lock).
// Latency: response one cycle after transfer; no response backpressure, requests stall via ready.
module alu_arbiter
    import sisc_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int IMM_W    = 16,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_f,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_lock,
    input  logic [DATA_W-1:0] req0_rsa,
    input  logic [DATA_W-1:0] req0_rsb,
    input  logic [IMM_W-1:0]  req0_imm,
    input  logic [1:0]        req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_lock,
    input  logic [DATA_W-1:0] req1_rsa,
    input  logic [DATA_W-1:0] req1_rsb,
    input  logic [IMM_W-1:0]  req1_imm,
    input  logic [1:0]        req1_op,

    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_result,
    output logic [3:0]        rsp0_stat,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_result,
    output logic [3:0]        rsp1_stat,

    output logic [3:0]        status0,
    output logic [3:0]        status1,
    output logic              lock_abort0,
    output logic              lock_abort1,

    output logic [DATA_W-1:0] alu_rsa,
    output logic [DATA_W-1:0] alu_rsb,
    output logic [IMM_W-1:0]  alu_imm,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_stat,
    input  logic              alu_stat_en
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    logic [1:0]       state;
    logic             last_grant;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] cnt_next;

    logic [1:0] arb_grant;
    logic [1:0] grant;
    logic       own_en;
    logic       own_port;
    logic       xfer;
    logic       gp;
    logic       g_lock;
    logic       lock_hit;

    logic [1:0] rsp_vld_q;
    logic [1:0] lock_abort_q;
    stat_t      rsp_stat_q [2];
    stat_t      status_q   [2];

    assign own_en   = (state != ST_ARB);
    assign own_port = (state == ST_OWN1);

    rr_arb2 u_rr_arb2 (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .own_en     (own_en),
        .own_port   (own_port),
        .grant      (arb_grant)
    );

    // nothing is accepted while reset is held
    assign grant      = arb_grant & {2{rst_f}};
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign xfer   = |grant;
    assign gp     = grant[1];
    assign g_lock = gp ? req1_lock : req0_lock;

    assign cnt_next = (state == ST_ARB) ? CNT_W'(1) : lock_cnt + CNT_W'(1);
    assign lock_hit = g_lock && (cnt_next == CNT_W'(LOCK_MAX));

    // idle drive is a no-stat op with zero operands so the ALU stays inert
    always_comb begin
        alu_rsa = '0;
        alu_rsb = '0;
        alu_imm = '0;
        alu_op  = ALU_OP_NOSTAT;
        if (grant[1]) begin
            alu_rsa = req1_rsa;
            alu_rsb = req1_rsb;
            alu_imm = req1_imm;
            alu_op  = req1_op;
        end else if (grant[0]) begin
            alu_rsa = req0_rsa;
            alu_rsb = req0_rsb;
            alu_imm = req0_imm;
            alu_op  = req0_op;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state        <= ST_ARB;
            last_grant   <= 1'b1;
            lock_cnt     <= '0;
            rsp_vld_q    <= 2'b00;
            lock_abort_q <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                rsp_stat_q[k] <= '0;
                status_q[k]   <= '0;
            end
        end else begin
            rsp_vld_q    <= grant;
            lock_abort_q <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                if (grant[k]) begin
                    rsp_stat_q[k] <= stat_t'(alu_stat);
                    if (alu_stat_en) begin
                        status_q[k] <= stat_t'(alu_stat);
                    end
                end
            end
            if (xfer) begin
                last_grant <= gp;
                if (!g_lock || lock_hit) begin
                    state              <= ST_ARB;
                    lock_cnt           <= '0;
                    lock_abort_q[gp]   <= lock_hit;
                end else begin
                    state    <= own_state(gp);
                    lock_cnt <= cnt_next;
                end
            end
        end
    end

    // a response still in flight when reset arrives is suppressed immediately
    assign rsp0_valid  = rsp_vld_q[0] & rst_f;
    assign rsp1_valid  = rsp_vld_q[1] & rst_f;
    assign rsp0_result = rsp0_valid ? alu_result : '0;
    assign rsp1_result = rsp1_valid ? alu_result : '0;
    assign rsp0_stat   = rsp_stat_q[0];
    assign rsp1_stat   = rsp_stat_q[1];
    assign status0     = status_q[0];
    assign status1     = status_q[1];
    assign lock_abort0 = lock_abort_q[0];
    assign lock_abort1 = lock_abort_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural SISC ALU model.
module tb_alu_arbiter;
    import sisc_pkg::*;

    localparam int LOCK_MAX = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_f;
    logic        req0_valid, req0_ready, req0_lock;
    logic [31:0] req0_rsa, req0_rsb;
    logic [15:0] req0_imm;
    logic [1:0]  req0_op;
    logic        req1_valid, req1_ready, req1_lock;
    logic [31:0] req1_rsa, req1_rsb;
    logic [15:0] req1_imm;
    logic [1:0]  req1_op;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_result, rsp1_result;
    logic [3:0]  rsp0_stat, rsp1_stat, status0, status1;
    logic        lock_abort0, lock_abort1;
    logic [31:0] alu_rsa, alu_rsb, alu_result;
    logic [15:0] alu_imm;
    logic [1:0]  alu_op;
    logic [3:0]  alu_stat;
    logic        alu_stat_en;

    alu_arbiter #(.DATA_W(32), .IMM_W(16), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst_f(rst_f),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_lock(req0_lock),
        .req0_rsa(req0_rsa), .req0_rsb(req0_rsb), .req0_imm(req0_imm), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_lock(req1_lock),
        .req1_rsa(req1_rsa), .req1_rsb(req1_rsb), .req1_imm(req1_imm), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_stat(rsp0_stat),
        .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_stat(rsp1_stat),
        .status0(status0), .status1(status1),
        .lock_abort0(lock_abort0), .lock_abort1(lock_abort1),
        .alu_rsa(alu_rsa), .alu_rsb(alu_rsb), .alu_imm(alu_imm), .alu_op(alu_op),
        .alu_result(alu_result), .alu_stat(alu_stat), .alu_stat_en(alu_stat_en)
    );

    // ALU model: funct in imm[3:0], op bit0 selects sign-extended imm as operand b
    logic [31:0] m_b, m_res;
    logic [32:0] m_sum;
    logic [3:0]  m_f;
    logic        m_c, m_v;
    always_comb begin
        m_b   = alu_op[ALU_OP_IMM] ? {{16{alu_imm[15]}}, alu_imm} : alu_rsb;
        m_f   = alu_imm[3:0];
        m_sum = '0;
        m_res = alu_rsa;
        m_c   = 1'b0;
        m_v   = 1'b0;
        case (m_f)
            FUNCT_ADD: begin
                m_sum = {1'b0, alu_rsa} + {1'b0, m_b};
                m_res = m_sum[31:0];
                m_c   = m_sum[32];
                m_v   = (alu_rsa[31] == m_b[31]) && (m_res[31] != alu_rsa[31]);
            end
            FUNCT_SUB: begin
                m_res = alu_rsa - m_b;
                m_c   = alu_rsa < m_b;
                m_v   = (alu_rsa[31] != m_b[31]) && (m_res[31] != alu_rsa[31]);
            end
            4'd5:    m_res = alu_rsa | m_b;
            default: m_res = alu_rsa;
        endcase
        alu_stat         = '0;
        alu_stat[STAT_C] = m_c;
        alu_stat[STAT_V] = m_v;
        alu_stat[STAT_N] = m_res[31];
        alu_stat[STAT_Z] = (m_res == 32'd0);
        alu_stat_en      = !alu_op[1] && ((m_f == FUNCT_ADD) || (m_f == FUNCT_SUB));
    end

    always @(posedge clk) alu_result <= m_res;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  vld, lck;
        logic [31:0] a0, b0, a1, b1;
        logic [15:0] i0, i1;
        logic [1:0]  o0, o1;
        logic [1:0]  exp_rdy;
        logic [31:0] exp_res;
        logic [3:0]  exp_stat, exp_st0, exp_st1;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] vld, input logic [1:0] lck,
                                input logic [31:0] a0, input logic [31:0] b0, input logic [15:0] i0, input logic [1:0] o0,
                                input logic [31:0] a1, input logic [31:0] b1, input logic [15:0] i1, input logic [1:0] o1,
                                input logic [1:0] rdy, input logic [31:0] res, input logic [3:0] stat,
                                input logic [3:0] st0, input logic [3:0] st1);
        vec_t v;
        v.vld = vld; v.lck = lck;
        v.a0 = a0; v.b0 = b0; v.i0 = i0; v.o0 = o0;
        v.a1 = a1; v.b1 = b1; v.i1 = i1; v.o1 = o1;
        v.exp_rdy = rdy; v.exp_res = res; v.exp_stat = stat;
        v.exp_st0 = st0; v.exp_st1 = st1;
        return v;
    endfunction

    task automatic run_vec(input int n, input vec_t v);
        req0_valid = v.vld[0]; req0_lock = v.lck[0];
        req0_rsa = v.a0; req0_rsb = v.b0; req0_imm = v.i0; req0_op = v.o0;
        req1_valid = v.vld[1]; req1_lock = v.lck[1];
        req1_rsa = v.a1; req1_rsb = v.b1; req1_imm = v.i1; req1_op = v.o1;
        #1;
        chk($sformatf("v%0d_ready", n), {30'd0, req1_ready, req0_ready}, {30'd0, v.exp_rdy});
        @(posedge clk); #1;
        chk($sformatf("v%0d_rsp_valid", n), {30'd0, rsp1_valid, rsp0_valid}, {30'd0, v.exp_rdy});
        if (v.exp_rdy != 2'b00) begin
            chk($sformatf("v%0d_result", n), v.exp_rdy[1] ? rsp1_result : rsp0_result, v.exp_res);
            chk($sformatf("v%0d_rsp_stat", n), {28'd0, v.exp_rdy[1] ? rsp1_stat : rsp0_stat}, {28'd0, v.exp_stat});
        end
        chk($sformatf("v%0d_status0", n), {28'd0, status0}, {28'd0, v.exp_st0});
        chk($sformatf("v%0d_status1", n), {28'd0, status1}, {28'd0, v.exp_st1});
        chk($sformatf("v%0d_abort", n), {30'd0, lock_abort1, lock_abort0}, 32'd0);
    endtask

    vec_t tbl [13];

    initial begin
        // both-valid round robin, port-0 status isolation
        tbl[0]  = mk(2'b11, 2'b00, 32'hFFFF_FFFF, 32'd1, 16'h0001, 2'b00, 32'h0F0, 32'h00F, 16'h0005, 2'b00, 2'b01, 32'h0, 4'b1001, 4'b1001, 4'b0000);
        tbl[1]  = mk(2'b11, 2'b00, 32'hFFFF_FFFF, 32'd1, 16'h0001, 2'b00, 32'h0F0, 32'h00F, 16'h0005, 2'b00, 2'b10, 32'h0FF, 4'b0000, 4'b1001, 4'b0000);
        tbl[2]  = mk(2'b11, 2'b00, 32'h7FFF_FFFF, 32'd1, 16'h0001, 2'b00, 32'h8000_0000, 32'd0, 16'h0005, 2'b00, 2'b01, 32'h8000_0000, 4'b0110, 4'b0110, 4'b0000);
        tbl[3]  = mk(2'b11, 2'b00, 32'h7FFF_FFFF, 32'd1, 16'h0001, 2'b00, 32'h8000_0000, 32'd0, 16'h0005, 2'b00, 2'b10, 32'h8000_0000, 4'b0010, 4'b0110, 4'b0000);
        // single requester ADD, immediate ADD, idle cycle
        tbl[4]  = mk(2'b01, 2'b00, 32'd5, 32'd7, 16'h0001, 2'b00, 32'd0, 32'd0, 16'h0000, 2'b00, 2'b01, 32'd12, 4'b0000, 4'b0000, 4'b0000);
        tbl[5]  = mk(2'b01, 2'b00, 32'h100, 32'd0, 16'h0011, 2'b01, 32'd0, 32'd0, 16'h0000, 2'b00, 2'b01, 32'h111, 4'b0000, 4'b0000, 4'b0000);
        tbl[6]  = mk(2'b00, 2'b00, 32'd0, 32'd0, 16'h0000, 2'b00, 32'd0, 32'd0, 16'h0000, 2'b00, 2'b00, 32'd0, 4'b0000, 4'b0000, 4'b0000);
        // port 1 SUB sets Z, following OR returns stat without touching status1
        tbl[7]  = mk(2'b10, 2'b00, 32'd0, 32'd0, 16'h0000, 2'b00, 32'd3, 32'd3, 16'h0002, 2'b00, 2'b10, 32'd0, 4'b0001, 4'b0000, 4'b0001);
        tbl[8]  = mk(2'b10, 2'b00, 32'd0, 32'd0, 16'h0000, 2'b00, 32'h8000_0000, 32'd1, 16'h0005, 2'b00, 2'b10, 32'h8000_0001, 4'b0010, 4'b0000, 4'b0001);
        // port 0 locks three ops while port 1 waits
        tbl[9]  = mk(2'b11, 2'b01, 32'd1, 32'd1, 16'h0001, 2'b00, 32'd10, 32'd20, 16'h0001, 2'b00, 2'b01, 32'd2, 4'b0000, 4'b0000, 4'b0001);
        tbl[10] = mk(2'b11, 2'b01, 32'd2, 32'd2, 16'h0001, 2'b00, 32'd10, 32'd20, 16'h0001, 2'b00, 2'b01, 32'd4, 4'b0000, 4'b0000, 4'b0001);
        tbl[11] = mk(2'b11, 2'b00, 32'd3, 32'd3, 16'h0001, 2'b00, 32'd10, 32'd20, 16'h0001, 2'b00, 2'b01, 32'd6, 4'b0000, 4'b0000, 4'b0001);
        tbl[12] = mk(2'b11, 2'b00, 32'd3, 32'd3, 16'h0001, 2'b00, 32'd10, 32'd20, 16'h0001, 2'b00, 2'b10, 32'h1E, 4'b0000, 4'b0000, 4'b0000);

        rst_f = 1'b0;
        req0_valid = 1'b1; req0_lock = 1'b0; req0_rsa = '0; req0_rsb = '0; req0_imm = '0; req0_op = 2'b00;
        req1_valid = 1'b1; req1_lock = 1'b0; req1_rsa = '0; req1_rsb = '0; req1_imm = '0; req1_op = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("rst_alu_op", {30'd0, alu_op}, {30'd0, ALU_OP_NOSTAT});
        chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_rsp0_result", rsp0_result, 32'd0);
        chk("rst_rsp_stat", {24'd0, rsp1_stat, rsp0_stat}, 32'd0);
        chk("rst_status", {24'd0, status1, status0}, 32'd0);
        chk("rst_abort", {30'd0, lock_abort1, lock_abort0}, 32'd0);
        rst_f = 1'b1;

        for (int n = 0; n < 13; n++) run_vec(n, tbl[n]);

        // lock held to the limit: forced release and abort pulse
        req1_valid = 1'b1; req1_lock = 1'b0;
        req1_rsa = 32'd40; req1_rsb = 32'd2; req1_imm = 16'h0001; req1_op = 2'b00;
        for (int i = 0; i < LOCK_MAX; i++) begin
            req0_valid = 1'b1; req0_lock = 1'b1;
            req0_rsa = i; req0_rsb = 32'd1; req0_imm = 16'h0001; req0_op = 2'b00;
            #1;
            chk($sformatf("lk%0d_ready", i), {30'd0, req1_ready, req0_ready}, 32'd1);
            @(posedge clk); #1;
            chk($sformatf("lk%0d_result", i), rsp0_result, i + 1);
            chk($sformatf("lk%0d_abort", i), {30'd0, lock_abort1, lock_abort0}, (i == LOCK_MAX - 1) ? 32'd1 : 32'd0);
        end
        #1;
        chk("lk_after_ready", {30'd0, req1_ready, req0_ready}, 32'd2);
        @(posedge clk); #1;
        chk("lk_after_abort", {30'd0, lock_abort1, lock_abort0}, 32'd0);
        chk("lk_after_rsp1", {31'd0, rsp1_valid}, 32'd1);
        chk("lk_after_result", rsp1_result, 32'd42);

        // reset right after a locked transfer
        req0_valid = 1'b1; req0_lock = 1'b1; req1_valid = 1'b0;
        #1;
        chk("rr_pre_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(posedge clk); #1;
        rst_f = 1'b0; req1_valid = 1'b1;
        #1;
        chk("rr_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("rr_alu_op", {30'd0, alu_op}, {30'd0, ALU_OP_NOSTAT});
        chk("rr_rsp_dropped", {31'd0, rsp0_valid}, 32'd0);
        @(posedge clk); #1;
        rst_f = 1'b1; req0_valid = 1'b0; req0_lock = 1'b0; req1_valid = 1'b1;
        chk("rr_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rr_status", {24'd0, status1, status0}, 32'd0);
        #1;
        chk("rr_lock_cleared", {30'd0, req1_ready, req0_ready}, 32'd2);
        req0_valid = 1'b1;
        #1;
        chk("rr_tie_port0", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(posedge clk); #1;
        chk("rr_rsp0", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
